// File: rtl/datetime_editor_pkg.sv
// Shared definitions for the date/time editor: cursor field indices,
// the calendar month-length table and the power-on date.
package datetime_editor_pkg;

   // Cursor positions, in the order btn_l walks through them
   localparam logic [2:0] FLD_SEC   = 3'd0;
   localparam logic [2:0] FLD_MIN   = 3'd1;
   localparam logic [2:0] FLD_HOUR  = 3'd2;
   localparam logic [2:0] FLD_DAY   = 3'd3;
   localparam logic [2:0] FLD_MONTH = 3'd4;
   localparam logic [2:0] FLD_YEAR  = 3'd5;

   // Date loaded by reset (2023-01-01 00:00:00, a Sunday)
   localparam int RST_YEAR  = 2023;
   localparam int RST_MONTH = 1;
   localparam int RST_DAY   = 1;

   // Non-leap month lengths, December in the top slot, January in the bottom
   localparam logic [59:0] MONTH_DAYS = {
      5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31,
      5'd30, 5'd31, 5'd30, 5'd31, 5'd28, 5'd31
   };

   // Which button action won arbitration this cycle
   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_MID,
      ACT_UP,
      ACT_DOWN,
      ACT_LEFT,
      ACT_RIGHT
   } action_e;

   // Non-leap length of month m (1..12)
   function automatic int base_month_days(input int m);
      int idx;
      idx = (m >= 1 && m <= 12) ? (m - 1) : 0;
      return int'(MONTH_DAYS[idx*5 +: 5]);
   endfunction

endpackage

// File: rtl/datetime_editor_btn.sv
// Press-and-hold qualifier for one button: fires after HOLD_CYCLES of
// continuous press, then optionally every REPEAT_CYCLES while still held.
module btn_qualifier #(
   parameter int HOLD_CYCLES   = 2500000,
   parameter int REPEAT_CYCLES = 500000,
   parameter bit REPEAT_EN     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic btn,
   output logic fire
);

   localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   logic [CW-1:0] cnt;
   logic          held_done;  // first action already fired for this press
   logic          active;

   assign active = btn && en;

   // Fire on the cycle the count reaches its target; the owner acts on this edge
   assign fire = active && (held_done ? (REPEAT_EN && (cnt == CW'(REPEAT_CYCLES - 1)))
                                      : (cnt == CW'(HOLD_CYCLES - 1)));

   // Hold/repeat counter, cleared whenever the button is released or editing is off
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         held_done <= 1'b0;
      end else if (!active) begin
         cnt       <= '0;
         held_done <= 1'b0;
      end else if (!held_done) begin
         if (cnt == CW'(HOLD_CYCLES - 1)) begin
            cnt       <= '0;
            held_done <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if (REPEAT_EN) begin
         if (cnt == CW'(REPEAT_CYCLES - 1)) cnt <= '0;
         else                               cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/datetime_editor.sv
// Five-button date/time editor: cursor moves with l/r, up/down step the
// selected field with calendar-aware wrap, mid emits a commit pulse.
module datetime_editor #(
   parameter int HOLD_CYCLES   = 2500000,
   parameter int REPEAT_CYCLES = 500000,
   parameter int YEAR_MIN      = 2000,
   parameter int YEAR_MAX      = 2099
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        edit_en,
   input  logic        btn_l,
   input  logic        btn_r,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_mid,
   output logic [15:0] year,
   output logic [7:0]  month,
   output logic [7:0]  day,
   output logic [7:0]  hour,
   output logic [7:0]  minute,
   output logic [7:0]  sec,
   output logic [2:0]  week,
   output logic [2:0]  field_sel,
   output logic        commit
);

   import datetime_editor_pkg::*;

   logic [13:0] year_r;
   logic [3:0]  month_r;
   logic [4:0]  day_r;
   logic [4:0]  hour_r;
   logic [5:0]  min_r;
   logic [5:0]  sec_r;
   logic        edit_en_q;

   logic fire_l, fire_r, fire_up, fire_down, fire_mid;
   action_e act;

   int year_n, month_n, day_n, hour_n, min_n, sec_n;
   logic [2:0] sel_n;

   function automatic logic is_leap(input int y);
      return ((y % 4) == 0) && (((y % 100) != 0) || ((y % 400) == 0));
   endfunction

   function automatic int days_in_month(input int m, input int y);
      if (m == 2 && is_leap(y)) return 29;
      return base_month_days(m);
   endfunction

   // Day of week, 0 = Sunday; Jan/Feb count as months 13/14 of the previous year
   function automatic logic [2:0] day_of_week(input int y, input int m, input int d);
      int mp, yp, w;
      mp = m;
      yp = y;
      if (m < 3) begin
         mp = m + 12;
         yp = y - 1;
      end
      w = (d + 2*mp + (3*(mp + 1))/5 + yp + yp/4 - yp/100 + yp/400 + 1) % 7;
      return 3'(w);
   endfunction

   function automatic int step_wrap(input int v, input int lo, input int hi, input logic up);
      if (up) return (v >= hi) ? lo : v + 1;
      return (v <= lo) ? hi : v - 1;
   endfunction

   function automatic logic [7:0] to_bcd8(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   btn_qualifier #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
      u_q_l    (.clk(clk), .rst_n(rst_n), .en(edit_en), .btn(btn_l),    .fire(fire_l));
   btn_qualifier #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
      u_q_r    (.clk(clk), .rst_n(rst_n), .en(edit_en), .btn(btn_r),    .fire(fire_r));
   btn_qualifier #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
      u_q_up   (.clk(clk), .rst_n(rst_n), .en(edit_en), .btn(btn_up),   .fire(fire_up));
   btn_qualifier #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
      u_q_down (.clk(clk), .rst_n(rst_n), .en(edit_en), .btn(btn_down), .fire(fire_down));
   btn_qualifier #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
      u_q_mid  (.clk(clk), .rst_n(rst_n), .en(edit_en), .btn(btn_mid),  .fire(fire_mid));

   // Pick the single winning action: mid > up > down > l > r
   always_comb begin
      act = ACT_NONE;
      if      (fire_mid)  act = ACT_MID;
      else if (fire_up)   act = ACT_UP;
      else if (fire_down) act = ACT_DOWN;
      else if (fire_l)    act = ACT_LEFT;
      else if (fire_r)    act = ACT_RIGHT;
   end

   // Next field values and cursor for the winning action, with day clamping
   always_comb begin
      year_n  = int'(year_r);
      month_n = int'(month_r);
      day_n   = int'(day_r);
      hour_n  = int'(hour_r);
      min_n   = int'(min_r);
      sec_n   = int'(sec_r);
      sel_n   = field_sel;
      case (act)
         ACT_UP, ACT_DOWN: begin
            case (field_sel)
               FLD_SEC:   sec_n  = step_wrap(int'(sec_r), 0, 59, act == ACT_UP);
               FLD_MIN:   min_n  = step_wrap(int'(min_r), 0, 59, act == ACT_UP);
               FLD_HOUR:  hour_n = step_wrap(int'(hour_r), 0, 23, act == ACT_UP);
               FLD_DAY:   day_n  = step_wrap(int'(day_r), 1,
                                      days_in_month(int'(month_r), int'(year_r)), act == ACT_UP);
               FLD_MONTH: begin
                  month_n = step_wrap(int'(month_r), 1, 12, act == ACT_UP);
                  day_n   = min_int(int'(day_r), days_in_month(month_n, int'(year_r)));
               end
               FLD_YEAR: begin
                  year_n = step_wrap(int'(year_r), YEAR_MIN, YEAR_MAX, act == ACT_UP);
                  day_n  = min_int(int'(day_r), days_in_month(int'(month_r), year_n));
               end
               default: ;
            endcase
         end
         ACT_LEFT:  sel_n = (field_sel == FLD_YEAR) ? FLD_SEC : field_sel + 3'd1;
         ACT_RIGHT: sel_n = (field_sel == FLD_SEC) ? FLD_YEAR : field_sel - 3'd1;
         default: ;
      endcase
   end

   // Field registers, cursor and commit pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         year_r    <= 14'(RST_YEAR);
         month_r   <= 4'(RST_MONTH);
         day_r     <= 5'(RST_DAY);
         hour_r    <= '0;
         min_r     <= '0;
         sec_r     <= '0;
         field_sel <= FLD_YEAR;
         commit    <= 1'b0;
         edit_en_q <= 1'b0;
      end else begin
         year_r    <= 14'(year_n);
         month_r   <= 4'(month_n);
         day_r     <= 5'(day_n);
         hour_r    <= 5'(hour_n);
         min_r     <= 6'(min_n);
         sec_r     <= 6'(sec_n);
         commit    <= (act == ACT_MID);
         edit_en_q <= edit_en;
         if (edit_en && !edit_en_q) field_sel <= FLD_YEAR;
         else                       field_sel <= sel_n;
      end
   end

   // Day of week follows the stored date one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) week <= 3'd0;
      else        week <= day_of_week(int'(year_r), int'(month_r), int'(day_r));
   end

   // BCD views of the binary registers
   always_comb begin
      year   = {4'(int'(year_r) / 1000), 4'((int'(year_r) / 100) % 10),
                4'((int'(year_r) / 10) % 10), 4'(int'(year_r) % 10)};
      month  = to_bcd8(int'(month_r));
      day    = to_bcd8(int'(day_r));
      hour   = to_bcd8(int'(hour_r));
      minute = to_bcd8(int'(min_r));
      sec    = to_bcd8(int'(sec_r));
   end

endmodule
